// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus (master_port / slave_port).
// Contents: slave FSM state encoding, transfer-mode constants and the default
// address/data/timeout sizes both ends of the bus agree on.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      MEMWR,
      MEMRD,
      WAITRD,
      RDATA
   } state_t;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_RD_TIMEOUT = 16;

endpackage

// File: rtl/slave_port_if.sv
// Serial bus signals between the bus side (address decoder / master_port) and
// a slave_port.
//   swdata  : serial address/write-data bit, LSB-first
//   smode   : 0 = read, 1 = write, meaningful with the first frame bit
//   mvalid  : frame bit valid (select-qualified)
//   srdata  : serial read-data bit, LSB-first
//   svalid  : srdata valid
//   sready  : slave idle, can accept a frame
interface slave_port_if;

   logic swdata;
   logic smode;
   logic mvalid;
   logic srdata;
   logic svalid;
   logic sready;

   modport master (
      output swdata, smode, mvalid,
      input  srdata, svalid, sready
   );

   modport slave (
      input  swdata, smode, mvalid,
      output srdata, svalid, sready
   );

endinterface

// File: rtl/slave_port_tx_serializer.sv
// Read-data serializer for slave_port.
// Loads a DATA_WIDTH word, then presents it LSB-first on srdata with svalid
// high for exactly DATA_WIDTH consecutive cycles.
//   clk, rstn : clock, synchronous active-high reset
//   load      : capture load_data; the first bit appears the next cycle
//   load_data : word to send
//   srdata    : serial bit (0 while idle)
//   svalid    : serial bit valid
//   done      : high during the last bit cycle
module slave_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  srdata,
   output logic                  svalid,
   output logic                  done
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;

   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (load) begin
         sh_d   = load_data;
         cnt_d  = CNT_W'(DATA_WIDTH - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         sh_d = sh_q >> 1;
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign srdata = busy_q & sh_q[0];
   assign svalid = busy_q;
   assign done   = busy_q && (cnt_q == '0);

endmodule

// File: rtl/slave_port.sv
// Responder end of the serial system bus.
// Deserializes an address (and, for writes, a data word) from the 1-bit bus,
// performs one access on a local synchronous memory port and, for reads,
// serializes the returned word back onto the bus.
//   clk, rstn    : clock, synchronous active-high reset
//   bus          : serial bus (slave_port_if.slave)
//   smemaddr     : memory address
//   smemwdata    : memory write data
//   smemwen      : one-cycle write strobe
//   smemren      : one-cycle read strobe
//   smemrdata    : memory read data, valid with smemrvalid
//   smemrvalid   : read data valid
//   serr         : sticky read-timeout flag
//
// state  | meaning
// IDLE   | sready=1, waiting for the first frame bit
// ADDR   | shifting in address bits
// WDATA  | shifting in write-data bits
// MEMWR  | smemwen pulse
// MEMRD  | smemren pulse, zero-latency read data accepted here
// WAITRD | waiting for smemrvalid, bounded by RD_TIMEOUT
// RDATA  | serializer sending the read word
module slave_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rstn,
   slave_port_if.slave           bus,
   output logic [ADDR_WIDTH-1:0] smemaddr,
   output logic [DATA_WIDTH-1:0] smemwdata,
   output logic                  smemwen,
   output logic                  smemren,
   input  logic [DATA_WIDTH-1:0] smemrdata,
   input  logic                  smemrvalid,
   output logic                  serr
);

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  mode_q, mode_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic                  serr_q, serr_d;
   logic                  ser_load;
   logic [DATA_WIDTH-1:0] ser_data;
   logic                  ser_done;

   // Address and data shift in from the top so the first (LSB) bit ends up
   // in bit 0 once the field is complete.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mode_d    = mode_q;
      bit_cnt_d = bit_cnt_q;
      tmr_d     = tmr_q;
      serr_d    = serr_q;
      ser_load  = 1'b0;
      ser_data  = '0;
      case (state_q)
         IDLE: begin
            if (bus.mvalid) begin
               addr_d    = {bus.swdata, addr_q[ADDR_WIDTH-1:1]};
               mode_d    = bus.smode;
               bit_cnt_d = CNT_W'(ADDR_WIDTH - 2);
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (!bus.mvalid) begin
               state_d = IDLE;
            end else begin
               addr_d = {bus.swdata, addr_q[ADDR_WIDTH-1:1]};
               if (bit_cnt_q == '0) begin
                  if (mode_q == MODE_WRITE) begin
                     bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
                     state_d   = WDATA;
                  end else begin
                     state_d = MEMRD;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q - CNT_W'(1);
               end
            end
         end
         WDATA: begin
            if (!bus.mvalid) begin
               state_d = IDLE;
            end else begin
               wdata_d = {bus.swdata, wdata_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == '0) begin
                  state_d = MEMWR;
               end else begin
                  bit_cnt_d = bit_cnt_q - CNT_W'(1);
               end
            end
         end
         MEMWR: begin
            state_d = IDLE;
         end
         MEMRD: begin
            if (smemrvalid) begin
               ser_load = 1'b1;
               ser_data = smemrdata;
               state_d  = RDATA;
            end else begin
               tmr_d   = TMR_W'(RD_TIMEOUT - 1);
               state_d = WAITRD;
            end
         end
         WAITRD: begin
            if (smemrvalid) begin
               ser_load = 1'b1;
               ser_data = smemrdata;
               state_d  = RDATA;
            end else if (tmr_q == '0) begin
               // Timed out: still complete the bus transfer, with zeros.
               ser_load = 1'b1;
               serr_d   = 1'b1;
               state_d  = RDATA;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         RDATA: begin
            if (ser_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         mode_q    <= MODE_READ;
         bit_cnt_q <= '0;
         tmr_q     <= '0;
         serr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mode_q    <= mode_d;
         bit_cnt_q <= bit_cnt_d;
         tmr_q     <= tmr_d;
         serr_q    <= serr_d;
      end
   end

   slave_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tx (
      .clk       (clk),
      .rstn      (rstn),
      .load      (ser_load),
      .load_data (ser_data),
      .srdata    (bus.srdata),
      .svalid    (bus.svalid),
      .done      (ser_done)
   );

   assign bus.sready = (state_q == IDLE);
   assign smemwen    = (state_q == MEMWR);
   assign smemren    = (state_q == MEMRD);
   assign smemaddr   = addr_q;
   assign smemwdata  = wdata_q;
   assign serr       = serr_q;

endmodule

// File: tb/tb_slave_port.sv
module tb_slave_port;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int TO = 16;
   localparam int NEVER = 999;

   typedef struct {
      logic          mode;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      int            abort_n;
      int            lat;
      logic [DW-1:0] mdata;
      int            rst_e;
      int            ne;
      int            x_wen_e;
      int            x_ren_e;
      int            x_sv_first;
      int            x_sv_cnt;
      logic [DW-1:0] x_word;
      int            x_rdy;
      logic          x_serr;
   } vec_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic [AW-1:0] smemaddr;
   logic [DW-1:0] smemwdata;
   logic          smemwen;
   logic          smemren;
   logic [DW-1:0] smemrdata;
   logic          smemrvalid;
   logic          serr;

   slave_port_if bus_if ();

   slave_port #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .bus        (bus_if),
      .smemaddr   (smemaddr),
      .smemwdata  (smemwdata),
      .smemwen    (smemwen),
      .smemren    (smemren),
      .smemrdata  (smemrdata),
      .smemrvalid (smemrvalid),
      .serr       (serr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic serr_m;

   int            o_wen_cnt, o_wen_e, o_ren_cnt, o_ren_e;
   int            o_sv_cnt, o_sv_first, o_sv_last, o_rdy;
   logic [AW-1:0] o_wen_addr, o_ren_addr;
   logic [DW-1:0] o_wen_data, o_word;
   logic          o_serr;

   vec_t tbl [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".sready"},    int'(bus_if.sready), 1);
      chk({tag, ".svalid"},    int'(bus_if.svalid), 0);
      chk({tag, ".srdata"},    int'(bus_if.srdata), 0);
      chk({tag, ".smemwen"},   int'(smemwen), 0);
      chk({tag, ".smemren"},   int'(smemren), 0);
      chk({tag, ".smemaddr"},  int'(smemaddr), 0);
      chk({tag, ".smemwdata"}, int'(smemwdata), 0);
      chk({tag, ".serr"},      int'(serr), 0);
   endtask

   // Transaction-level expectations from the bus rules: frame of AW (+DW) bits
   // starting at edge 0, memory answering lat cycles after the read strobe.
   function automatic vec_t predict(input logic mode, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input int ab,
                                    input int lat, input logic [DW-1:0] md);
      vec_t v;
      int   len;
      len          = mode ? AW + DW : AW;
      v.mode       = mode;
      v.addr       = a;
      v.wd         = d;
      v.abort_n    = ab;
      v.lat        = lat;
      v.mdata      = md;
      v.rst_e      = -1;
      v.x_wen_e    = -1;
      v.x_ren_e    = -1;
      v.x_sv_first = -1;
      v.x_sv_cnt   = 0;
      v.x_word     = '0;
      if (ab >= 0) begin
         v.x_rdy = ab;
      end else if (mode) begin
         v.x_wen_e = len - 1;
         v.x_rdy   = len;
      end else begin
         v.x_ren_e    = AW - 1;
         v.x_sv_first = AW + ((lat > TO) ? TO : lat);
         v.x_sv_cnt   = DW;
         v.x_word     = (lat > TO) ? '0 : md;
         v.x_rdy      = v.x_sv_first + DW;
         if (lat > TO) serr_m = 1'b1;
      end
      v.x_serr = serr_m;
      v.ne     = v.x_rdy + 1;
      return v;
   endfunction

   // Drives one frame for v.ne edges, starting at a falling edge; observation
   // index e is the DUT state just after rising edge e.
   task automatic run_frame(input vec_t v);
      logic [AW+DW-1:0] bits;
      int               len;
      int               ren_seen;
      logic             rdy_now;
      bits       = {v.wd, v.addr};
      len        = v.mode ? AW + DW : AW;
      o_wen_cnt  = 0; o_wen_e = -1; o_ren_cnt = 0; o_ren_e = -1;
      o_sv_cnt   = 0; o_sv_first = -1; o_sv_last = -1; o_rdy = -1;
      o_wen_addr = '0; o_wen_data = '0; o_ren_addr = '0; o_word = '0;
      ren_seen   = -1;
      rdy_now    = bus_if.sready;
      for (int e = 0; e < v.ne; e++) begin
         rstn = (e == v.rst_e);
         if (e < len && (v.abort_n < 0 || e < v.abort_n)) begin
            bus_if.mvalid = 1'b1;
            bus_if.swdata = bits[5'(e)];
         end else if (!rdy_now && e >= len && v.abort_n < 0) begin
            bus_if.mvalid = 1'($urandom);
            bus_if.swdata = 1'($urandom);
         end else begin
            bus_if.mvalid = 1'b0;
            bus_if.swdata = 1'($urandom);
         end
         bus_if.smode = (e == 0) ? v.mode : 1'($urandom);
         if (ren_seen >= 0 && v.lat != NEVER && e == ren_seen + 1 + v.lat) begin
            smemrvalid = 1'b1;
            smemrdata  = v.mdata;
         end else if (ren_seen < 0) begin
            smemrvalid = 1'($urandom);
            smemrdata  = DW'($urandom);
         end else begin
            smemrvalid = 1'b0;
            smemrdata  = DW'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         if (smemwen) begin
            o_wen_cnt++;
            o_wen_e    = e;
            o_wen_addr = smemaddr;
            o_wen_data = smemwdata;
         end
         if (smemren) begin
            o_ren_cnt++;
            o_ren_e    = e;
            o_ren_addr = smemaddr;
            if (ren_seen < 0) ren_seen = e;
         end
         if (bus_if.svalid) begin
            if (o_sv_cnt == 0) o_sv_first = e;
            o_sv_last = e;
            if (o_sv_cnt < DW) o_word[3'(o_sv_cnt)] = bus_if.srdata;
            o_sv_cnt++;
         end
         if (bus_if.sready && o_rdy < 0) o_rdy = e;
         rdy_now = bus_if.sready;
      end
      rstn   = 1'b0;
      o_serr = serr;
   endtask

   task automatic check_frame(input string tag, input vec_t v);
      chk({tag, ".wen_cnt"}, o_wen_cnt, (v.x_wen_e >= 0) ? 1 : 0);
      if (v.x_wen_e >= 0) begin
         chk({tag, ".wen_cycle"}, o_wen_e, v.x_wen_e);
         chk({tag, ".wen_addr"},  int'(o_wen_addr), int'(v.addr));
         chk({tag, ".wen_data"},  int'(o_wen_data), int'(v.wd));
      end
      chk({tag, ".ren_cnt"}, o_ren_cnt, (v.x_ren_e >= 0) ? 1 : 0);
      if (v.x_ren_e >= 0) begin
         chk({tag, ".ren_cycle"}, o_ren_e, v.x_ren_e);
         chk({tag, ".ren_addr"},  int'(o_ren_addr), int'(v.addr));
      end
      chk({tag, ".svalid_cnt"}, o_sv_cnt, v.x_sv_cnt);
      if (v.x_sv_cnt > 0) begin
         chk({tag, ".svalid_first"}, o_sv_first, v.x_sv_first);
         chk({tag, ".svalid_last"},  o_sv_last, v.x_sv_first + v.x_sv_cnt - 1);
         chk({tag, ".rd_word"},      int'(o_word), int'(v.x_word));
      end
      chk({tag, ".sready_cycle"}, o_rdy, v.x_rdy);
      chk({tag, ".serr"}, int'(o_serr), int'(v.x_serr));
   endtask

   initial begin
      vec_t v;
      logic          r_mode;
      logic [AW-1:0] r_addr;
      logic [DW-1:0] r_wd, r_md;
      int            r_ab, r_lat, r_len;

      //            mode  addr     wd     abort lat    mdata  rst  ne  wen ren svf svc word   rdy serr
      tbl[0] = '{1'b1, 12'h5A3, 8'hC6, -1, 0,     8'h00, -1, 40, 19, -1, -1, 0, 8'h00, 20, 1'b0};
      tbl[1] = '{1'b0, 12'h5A3, 8'h00, -1, 0,     8'hC6, -1, 40, -1, 11, 12, 8, 8'hC6, 20, 1'b0};
      tbl[2] = '{1'b0, 12'h2B4, 8'h00, -1, 3,     8'h3F, -1, 40, -1, 11, 15, 8, 8'h3F, 23, 1'b0};
      tbl[3] = '{1'b1, 12'h7FF, 8'h55, 7,  0,     8'h00, -1, 10, -1, -1, -1, 0, 8'h00, 7,  1'b0};
      tbl[4] = '{1'b1, 12'h001, 8'hFF, -1, 0,     8'h00, -1, 21, 19, -1, -1, 0, 8'h00, 20, 1'b0};
      tbl[5] = '{1'b0, 12'h5A3, 8'h00, -1, 0,     8'hA5, 16, 30, -1, 11, 12, 4, 8'h05, 16, 1'b0};
      tbl[6] = '{1'b0, 12'h123, 8'h00, -1, 1,     8'h96, -1, 40, -1, 11, 13, 8, 8'h96, 21, 1'b0};
      tbl[7] = '{1'b0, 12'hE0D, 8'h00, -1, NEVER, 8'h77, -1, 40, -1, 11, 28, 8, 8'h00, 36, 1'b1};

      rstn          = 1'b1;
      bus_if.swdata = 1'b0;
      bus_if.smode  = 1'b0;
      bus_if.mvalid = 1'b0;
      smemrdata     = '0;
      smemrvalid    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("por");
      rstn = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_frame(tbl[i]);
         check_frame($sformatf("tbl%0d", i), tbl[i]);
         if (i == 5) check_reset("rst_in_rdata");
      end
      serr_m = 1'b1;

      // Back-to-back: read starts in the first IDLE cycle after a write.
      v = predict(1'b1, 12'hABC, 8'h5E, -1, 0, 8'h00);
      run_frame(v);
      check_frame("b2b_wr", v);
      v = predict(1'b0, 12'hABC, 8'h00, -1, 0, 8'h5E);
      run_frame(v);
      check_frame("b2b_rd", v);

      for (int k = 0; k < 40; k++) begin
         r_mode = 1'($urandom);
         r_addr = AW'($urandom);
         r_wd   = DW'($urandom);
         r_md   = DW'($urandom);
         r_len  = r_mode ? AW + DW : AW;
         r_ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, r_len - 1)) : -1;
         r_lat  = int'($urandom_range(0, TO + 4));
         v = predict(r_mode, r_addr, r_wd, r_ab, r_lat, r_md);
         run_frame(v);
         check_frame($sformatf("rnd%0d", k), v);
      end

      // serr is sticky until reset.
      chk("serr_sticky", int'(serr), 1);
      bus_if.mvalid = 1'b0;
      smemrvalid    = 1'b0;
      rstn          = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("final_rst");
      rstn = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
Responder end of the serial system bus that master_port initiates on.
- Deserializes the address and write-data frame arriving on the 1-bit bus write line.
- Performs a single-cycle access on a local synchronous memory interface.
- For reads, serializes the memory data back onto the 1-bit read line with a valid strobe.
- Asserts sready whenever it can accept a new frame, so the arbiter can release or regrant the bus.

Parameters:
ADDR_WIDTH, 12, slave memory address bits (bus address minus device-select bits)
DATA_WIDTH, 8, data word width
RD_TIMEOUT, 16, maximum cycles to wait for smemrvalid before aborting a read

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  reset; synchronous, active-high (port keeps the codebase name)
swdata  in  1  serial address/write-data bit from bus, LSB-first
smode  in  1  0 = read, 1 = write; sampled with the first frame bit
mvalid  in  1  frame bit valid, from address decoder (select-qualified)
srdata  out  1  serial read-data bit to bus, LSB-first
svalid  out  1  srdata valid
sready  out  1  1 = idle, can accept a frame
smemaddr  out  ADDR_WIDTH  memory address
smemwdata  out  DATA_WIDTH  memory write data
smemwen  out  1  one-cycle memory write strobe
smemren  out  1  one-cycle memory read strobe
smemrdata  in  DATA_WIDTH  memory read data, valid with smemrvalid
smemrvalid  in  1  read data valid
serr  out  1  sticky read-timeout flag, cleared by reset only

Behaviour:
Reset values (rstn=1 at a clk edge):
- State IDLE; all counters 0.
- sready=1; svalid=0; srdata=0; smemwen=0; smemren=0; smemaddr=0; smemwdata=0; serr=0.
- Reset mid-frame drops the frame with no memory access.

Frame format and sampling:
- One bit per cycle while mvalid=1.
- ADDR_WIDTH address bits, LSB-first.
- Write frames follow with DATA_WIDTH data bits, LSB-first.

States and transitions:
- IDLE: sready=1. Edge with mvalid=1 samples addr bit0, latches smode, goes to ADDR; sready=0 from the next cycle.
- ADDR: sample one bit per edge. After bit ADDR_WIDTH-1: write goes to WDATA, read goes to MEMRD.
- WDATA: sample DATA_WIDTH bits. After the last bit, go to MEMWR.
- MEMWR: smemwen=1 for exactly one cycle with smemaddr/smemwdata stable. Next edge goes to IDLE.
- MEMRD: smemren=1 for exactly one cycle, then WAITRD. smemrvalid is also sampled in MEMRD (zero-latency memory allowed).
- WAITRD: on smemrvalid=1, latch smemrdata and go to RDATA. After RD_TIMEOUT cycles without it: latch all-zeros, set serr=1, go to RDATA.
- RDATA: svalid=1 for exactly DATA_WIDTH consecutive cycles; srdata = bit i in cycle i. Then IDLE; sready=1 in the first cycle svalid=0.

Abort and ignore rules:
- mvalid=0 during ADDR or WDATA aborts: return to IDLE next cycle, no memory strobe, no error.
- mvalid and swdata are ignored in MEMWR, MEMRD, WAITRD and RDATA.
- smode is sampled only on the first bit; later changes are ignored.
- smemrvalid outside MEMRD/WAITRD is ignored.

Latency (default widths, bit0 sampled at edge 0):
- Write: smemwen high in the cycle after edge 19; sready=1 after edge 20.
- Read (zero-latency memory): smemren after edge 11; svalid after edge 12 for 8 cycles; sready=1 after edge 20.

Back-to-back: a frame may start in the first IDLE cycle.

Decomposition:
- Package bus_pkg:
  - state enum (IDLE, ADDR, WDATA, MEMWR, MEMRD, WAITRD, RDATA)
  - mode constants MODE_READ=0, MODE_WRITE=1
  - default width constants shared with master_port
- Sub-module slave_tx_serializer: load DATA_WIDTH word, shift LSB-first, drive srdata/svalid, pulse done.

Test Plan:
1. Write addr 0x5A3, data 0xC6, mvalid held 20 cycles -> one smemwen pulse with smemaddr=0x5A3, smemwdata=0xC6; sready=1 after 21 cycles.
2. Read addr 0x5A3, zero-latency memory returning 0xC6 -> one smemren pulse; svalid 8 cycles, srdata sequence 0,1,1,0,0,0,1,1; serr=0.
3. Read with smemrvalid 3 cycles after smemren (data 0x3F) -> svalid starts the cycle after smemrvalid, serial value 0x3F.
4. Read with smemrvalid never asserted -> after 16 WAITRD cycles, 8 svalid cycles of 0, serr=1 until reset.
5. mvalid drops after 7 address bits, then a valid write to 0x001/0xFF -> no strobe for the aborted frame; exactly one smemwen at 0x001/0xFF.
6. rstn=1 during RDATA bit 3 -> next cycle svalid=0, sready=1, all outputs at reset values; the following read completes normally.
